// File: rtl/mem_stage_ctrl.sv
// MEM-stage data-memory access controller.
// Runs one req/ack data-bus transaction per load/store and stalls the pipeline
// until the transaction completes or times out. Each access passes IDLE -> BUSY -> DONE.
// Optional feature macro: MEMSTAGE_ALIGN_CHECK_EN (misaligned accesses are aborted
// without a bus request).
module mem_stage_ctrl #(
   parameter int unsigned TIMEOUT_CYC = 255,
   parameter logic [31:0] ERR_RDATA   = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_MemRead,
   input  logic        mem_MemWrite,
   input  logic [31:0] ExMem_AluResult,
   input  logic [31:0] ExMem_WriteData,
   output logic [31:0] DataMemory_ReadData,
   output logic        mem_stall,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic        bus_err,
   output logic        misalign_err
);

   localparam logic [15:0] CntLast = 16'(TIMEOUT_CYC - 1);

   typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        bus_err_q, bus_err_d;
   logic        mis_err_q, mis_err_d;

   logic op;
   logic misaligned;

   assign op = mem_MemRead | mem_MemWrite;

`ifdef MEMSTAGE_ALIGN_CHECK_EN
   assign misaligned = |ExMem_AluResult[1:0];
`else
   // Byte-offset bits are simply dropped from the bus address.
   logic unused_addr_lsb;
   assign unused_addr_lsb = ^ExMem_AluResult[1:0];
   assign misaligned      = 1'b0;
`endif

   // State, bus and result registers; async active-low reset returns everything to idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         cnt_q     <= '0;
         req_q     <= 1'b0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         bus_err_q <= 1'b0;
         mis_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         req_q     <= req_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
         bus_err_q <= bus_err_d;
         mis_err_q <= mis_err_d;
      end
   end

   // Next-state logic and combinational stall; error flags default low so they pulse once.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      req_d     = req_q;
      we_d      = we_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      bus_err_d = 1'b0;
      mis_err_d = 1'b0;
      mem_stall = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (op) begin
               mem_stall = 1'b1;
               if (misaligned) begin
                  mis_err_d = 1'b1;
                  if (!mem_MemWrite) rdata_d = ERR_RDATA;
                  state_d = StDone;
               end else begin
                  // Write has priority when both controls are set.
                  req_d   = 1'b1;
                  we_d    = mem_MemWrite;
                  addr_d  = {ExMem_AluResult[31:2], 2'b00};
                  wdata_d = ExMem_WriteData;
                  cnt_d   = '0;
                  state_d = StBusy;
               end
            end
         end
         StBusy: begin
            mem_stall = 1'b1;
            cnt_d     = cnt_q + 16'd1;
            // Ack is checked first so a same-cycle timeout is not flagged.
            if (dbus_ack) begin
               req_d = 1'b0;
               if (!we_q) rdata_d = dbus_rdata;
               state_d = StDone;
            end else if (cnt_q == CntLast) begin
               req_d     = 1'b0;
               bus_err_d = 1'b1;
               if (!we_q) rdata_d = ERR_RDATA;
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   assign DataMemory_ReadData = rdata_q;
   assign dbus_req            = req_q;
   assign dbus_we             = we_q;
   assign dbus_addr           = addr_q;
   assign dbus_wdata          = wdata_q;
   assign bus_err             = bus_err_q;
   assign misalign_err        = mis_err_q;

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Self-checking bench for mem_stage_ctrl: directed cases followed by randomized
// transactions, each checked cycle by cycle against a transaction-level expectation.
module tb_mem_stage_ctrl;

   localparam int unsigned TO   = 5;
   localparam logic [31:0] ERRV = 32'hDEAD_0BAD;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        mem_MemRead, mem_MemWrite;
   logic [31:0] ExMem_AluResult, ExMem_WriteData;
   logic [31:0] DataMemory_ReadData;
   logic        mem_stall;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
   logic        dbus_ack;
   logic        bus_err, misalign_err;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] rd_model = 32'h0;  // what the last completed load should have left in ReadData

   mem_stage_ctrl #(
      .TIMEOUT_CYC(TO),
      .ERR_RDATA  (ERRV)
   ) dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .mem_MemRead        (mem_MemRead),
      .mem_MemWrite       (mem_MemWrite),
      .ExMem_AluResult    (ExMem_AluResult),
      .ExMem_WriteData    (ExMem_WriteData),
      .DataMemory_ReadData(DataMemory_ReadData),
      .mem_stall          (mem_stall),
      .dbus_req           (dbus_req),
      .dbus_we            (dbus_we),
      .dbus_addr          (dbus_addr),
      .dbus_wdata         (dbus_wdata),
      .dbus_rdata         (dbus_rdata),
      .dbus_ack           (dbus_ack),
      .bus_err            (bus_err),
      .misalign_err       (misalign_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_bad++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Runs one access starting just after a rising edge with the DUT idle.
   // wait_c = number of BUSY cycles before ack (>= TO means the bus never answers).
   task automatic txn(input logic rd, input logic wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] rdata,
                      input int wait_c, input bit back_to_back);
      logic        is_load;
      logic [31:0] exp_addr;
      bit          mis;
      bit          timed_out;
      int          nb;
      is_load   = rd & ~wr;
      exp_addr  = addr & 32'hFFFF_FFFC;
      timed_out = 1'b0;
`ifdef MEMSTAGE_ALIGN_CHECK_EN
      mis = (addr[1:0] != 2'b00);
`else
      mis = 1'b0;
`endif
      mem_MemRead     = rd;
      mem_MemWrite    = wr;
      ExMem_AluResult = addr;
      ExMem_WriteData = wdata;
      dbus_ack        = 1'($urandom_range(0, 1));  // stray ack while idle must be ignored
      dbus_rdata      = $urandom;
      @(negedge clk);
      chk("idle_stall", mem_stall, 1);
      chk("idle_req", dbus_req, 0);
      chk("idle_rdata", DataMemory_ReadData, rd_model);
      @(posedge clk); #1;
      if (!mis) begin
         timed_out = (wait_c >= int'(TO));
         nb        = timed_out ? int'(TO) : wait_c + 1;
         for (int i = 0; i < nb; i++) begin
            dbus_ack   = (i == wait_c);
            dbus_rdata = (i == wait_c) ? rdata : $urandom;
            @(negedge clk);
            chk("busy_req", dbus_req, 1);
            chk("busy_we", dbus_we, wr);
            chk("busy_addr", dbus_addr, exp_addr);
            chk("busy_wdata", dbus_wdata, wdata);
            chk("busy_stall", mem_stall, 1);
            chk("busy_bus_err", bus_err, 0);
            @(posedge clk); #1;
         end
         if (is_load) rd_model = timed_out ? ERRV : rdata;
      end else if (is_load) begin
         rd_model = ERRV;
      end
      dbus_ack   = 1'b1;  // stray ack in DONE must not touch ReadData
      dbus_rdata = $urandom;
      @(negedge clk);
      chk("done_stall", mem_stall, 0);
      chk("done_req", dbus_req, 0);
      chk("done_rdata", DataMemory_ReadData, rd_model);
      chk("done_bus_err", bus_err, {31'b0, timed_out});
      chk("done_mis_err", misalign_err, {31'b0, mis});
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      if (!back_to_back) begin
         mem_MemRead  = 1'b0;
         mem_MemWrite = 1'b0;
         @(negedge clk);
         chk("nop_stall", mem_stall, 0);
         chk("nop_req", dbus_req, 0);
         chk("nop_rdata", DataMemory_ReadData, rd_model);
         chk("nop_bus_err", bus_err, 0);
         chk("nop_mis_err", misalign_err, 0);
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] a;
      int          r;
      rst_n           = 1'b0;
      mem_MemRead     = 1'b0;
      mem_MemWrite    = 1'b0;
      ExMem_AluResult = 32'h0;
      ExMem_WriteData = 32'h0;
      dbus_rdata      = 32'h0;
      dbus_ack        = 1'b0;
      #12;
      chk("rst_req", dbus_req, 0);
      chk("rst_we", dbus_we, 0);
      chk("rst_addr", dbus_addr, 0);
      chk("rst_wdata", dbus_wdata, 0);
      chk("rst_rdata", DataMemory_ReadData, 0);
      chk("rst_bus_err", bus_err, 0);
      chk("rst_mis_err", misalign_err, 0);
      chk("rst_stall", mem_stall, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      txn(1'b1, 1'b0, 32'h0000_0100, 32'h0, 32'hCAFE_BABE, 2, 1'b0);
      txn(1'b0, 1'b1, 32'h0000_0104, 32'h1234_5678, 32'h0BAD_F00D, 0, 1'b0);
      txn(1'b1, 1'b0, 32'h0000_0300, 32'h0, 32'h1357_9BDF, TO + 2, 1'b0);
      txn(1'b1, 1'b0, 32'h0000_0308, 32'h0, 32'h55AA_55AA, TO - 1, 1'b0);
      txn(1'b1, 1'b1, 32'h0000_030C, 32'h0000_A5A5, 32'h1111_1111, 1, 1'b0);
      txn(1'b1, 1'b0, 32'h0000_0200, 32'h0, 32'h2222_0200, 0, 1'b1);
      txn(1'b1, 1'b0, 32'h0000_0204, 32'h0, 32'h2222_0204, 0, 1'b0);
      txn(1'b1, 1'b0, 32'h0000_0102, 32'h0, 32'h7777_7777, 0, 1'b0);
      txn(1'b0, 1'b1, 32'h0000_0401, 32'h8888_8888, 32'h0, 1, 1'b0);

      for (int k = 0; k < 30; k++) begin
         r = int'($urandom_range(0, 2));
         a = $urandom;
         a[1:0] = 2'b00;
         txn(r != 1, r != 0, a, $urandom, $urandom, int'($urandom_range(0, TO + 2)),
             1'($urandom_range(0, 1)));
      end

      // Reset while BUSY, then a late ack that must be ignored.
      mem_MemRead     = 1'b1;
      mem_MemWrite    = 1'b0;
      ExMem_AluResult = 32'h0000_0400;
      @(posedge clk); #1;
      mem_MemRead = 1'b0;
      @(negedge clk);
      chk("pre_rst_req", dbus_req, 1);
      #1;
      rst_n = 1'b0;
      #1;
      rd_model = 32'h0;
      chk("midrst_req", dbus_req, 0);
      chk("midrst_rdata", DataMemory_ReadData, 0);
      chk("midrst_stall", mem_stall, 0);
      @(posedge clk); #1;
      rst_n      = 1'b1;
      dbus_ack   = 1'b1;
      dbus_rdata = 32'hFFFF_0000;
      @(negedge clk);
      chk("lateack_stall", mem_stall, 0);
      chk("lateack_req", dbus_req, 0);
      @(posedge clk); #1;
      dbus_ack = 1'b0;
      @(negedge clk);
      chk("postack_req", dbus_req, 0);
      chk("postack_rdata", DataMemory_ReadData, 0);
      chk("postack_bus_err", bus_err, 0);
      @(posedge clk); #1;
      txn(1'b1, 1'b0, 32'h0000_0500, 32'h0, 32'h0AB0_0500, 1, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
